// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   IfuResetPc : default PC loaded on reset
//   IfuInstNop : instruction word presented to decode while no fetch has completed
//   ifu_state_e: fetch FSM state encoding (2-bit)
//   pc_sel_e   : next-PC source select for ifu_pc_reg
package inst_fetch_pkg;

    localparam logic [31:0] IfuResetPc = 32'h8000_0000;
    localparam logic [31:0] IfuInstNop = 32'h0000_0013;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StReq  = 2'b01,
        StWait = 2'b10,
        StOut  = 2'b11
    } ifu_state_e;

    typedef enum logic [1:0] {
        PcHold     = 2'b00,
        PcInc      = 2'b01,
        PcRedirect = 2'b10
    } pc_sel_e;

    // Word alignment: the low two address bits are always zero.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_pc_reg.sv
// Program counter register for the fetch unit.
//   clk_i          : clock
//   rst_i          : asynchronous active-high reset, loads ResetPc
//   pc_sel_i       : next-PC select (hold / +4 / redirect)
//   redirect_pc_i  : redirect target, low two bits masked off
//   pc_o           : current word-aligned PC
module ifu_pc_reg
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] ResetPc = IfuResetPc
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  pc_sel_e     pc_sel_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc_o
);

    logic [31:0] pc_d;
    logic [31:0] pc_q;

    always_comb begin
        pc_d = pc_q;
        unique case (pc_sel_i)
            PcInc:      pc_d = pc_q + 32'd4;   // wraps modulo 2^32
            PcRedirect: pc_d = align_word(redirect_pc_i);
            default:    pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= align_word(ResetPc);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, issues one word read at a time to instruction
// memory, absorbs a variable-latency response and holds the word for decode.
//   clk, rst                    : clock, asynchronous active-high reset
//   imem_req_valid/ready/addr   : read request channel (addr = pc)
//   imem_rsp_valid/data         : single-cycle response pulse, one per accepted request
//   redirect_valid/redirect_pc  : restart fetch at redirect_pc, discarding stale fetches
//   inst_valid/ready            : valid/ready handshake towards decode
//   inst_out/pc_out             : fetched instruction word and its PC
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IfuResetPc
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out
);

    ifu_state_e  state_q, state_d;
    logic        drop_q, drop_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_out_q, pc_out_d;
    pc_sel_e     pc_sel;
    logic [31:0] pc;

    ifu_pc_reg #(
        .ResetPc (RESET_PC)
    ) u_pc_reg (
        .clk_i         (clk),
        .rst_i         (rst),
        .pc_sel_i      (pc_sel),
        .redirect_pc_i (redirect_pc),
        .pc_o          (pc)
    );

    always_comb begin
        state_d  = state_q;
        drop_d   = drop_q;
        inst_d   = inst_q;
        pc_out_d = pc_out_q;
        pc_sel   = PcHold;
        unique case (state_q)
            StIdle: begin
                state_d = StReq;
            end
            StReq: begin
                if (redirect_valid) begin
                    pc_sel = PcRedirect;
                end
                if (imem_req_ready) begin
                    state_d = StWait;
                    // Request went out with the old PC; its response is stale.
                    if (redirect_valid) begin
                        drop_d = 1'b1;
                    end
                end
            end
            StWait: begin
                if (imem_rsp_valid) begin
                    if (drop_q || redirect_valid) begin
                        drop_d  = 1'b0;
                        state_d = StReq;
                        if (redirect_valid) begin
                            pc_sel = PcRedirect;
                        end
                    end else begin
                        inst_d   = imem_rsp_data;
                        pc_out_d = pc;
                        pc_sel   = PcInc;
                        state_d  = StOut;
                    end
                end else if (redirect_valid) begin
                    // Still one response outstanding: must absorb it before refetching.
                    pc_sel = PcRedirect;
                    drop_d = 1'b1;
                end
            end
            StOut: begin
                if (redirect_valid) begin
                    pc_sel  = PcRedirect;
                    state_d = StReq;
                end else if (inst_ready) begin
                    state_d = StReq;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            drop_q   <= 1'b0;
            inst_q   <= IfuInstNop;
            pc_out_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            drop_q   <= drop_d;
            inst_q   <= inst_d;
            pc_out_q <= pc_out_d;
        end
    end

    assign imem_req_valid = (state_q == StReq);
    assign imem_req_addr  = pc;
    assign inst_valid     = (state_q == StOut);
    assign inst_out       = inst_q;
    assign pc_out         = pc_out_q;

endmodule
